// File: rtl/spi_target_bridge.sv
// spi_target_bridge: SPI mode-0 target that turns host read/write commands into OBI-style memory requests.
// Optional SPI_TGT_STATUS_CMD_EN adds command 0x05 returning the sticky {late, ovf} status byte.
module spi_target_bridge #(
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32,
    parameter int SyncStages = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   spi_sck_i,
    input  logic                   spi_cs_ni,
    input  logic                   spi_mosi_i,
    output logic                   spi_miso_o,
    output logic                   spi_miso_en_o,
    output logic                   req_o,
    output logic                   we_o,
    output logic [AddrWidth-1:0]   addr_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    input  logic                   gnt_i,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i,
    output logic                   busy_o
);
    localparam int SW = AddrWidth > DataWidth ? AddrWidth : DataWidth;
    localparam int CW = $clog2(SW) + 1;
    localparam logic [AddrWidth-1:0] STEP = AddrWidth'(DataWidth / 8);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE, STATUS} state_t;
    state_t state, state_nxt;

    logic [SyncStages-1:0] sck_sr, cs_sr, mosi_sr;
    logic sck_d, cs_d, sck_s, cs_s, mosi_s, rise, fall, cs_fall, tick, wrap;
    logic [CW-1:0] cnt, len;
    logic [SW-1:0] sin, sin_nxt;
    logic [7:0] stat_byte;
    logic [DataWidth-1:0] sout, rbuf, word, wdata_q;
    logic [AddrWidth-1:0] cur, cap_addr, addr_q;
    logic is_read, req_q, we_q, rd_out, rd_pend, rbuf_v, drop, free, inflight;
    logic cmd_done, addr_done, word_done, load, stat_load, rv_ok, avail, rd_trig, rd_issue, wr_go, status_cmd;

    assign sck_s     = sck_sr[SyncStages-1];
    assign cs_s      = cs_sr[SyncStages-1];
    assign mosi_s    = mosi_sr[SyncStages-1];
    assign rise      = sck_s & ~sck_d;
    assign fall      = ~sck_s & sck_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign sin_nxt   = {sin[SW-2:0], mosi_s};
    assign cap_addr  = {sin_nxt[AddrWidth-1:2], 2'b00};
    // MISO-driving states advance on sck fall, receiving states on sck rise
    assign tick      = ~cs_s & (state == RDATA || state == STATUS ? fall : rise);
    assign len       = state == CMD || state == DUMMY || state == STATUS ? CW'(8) : state == ADDR ? CW'(AddrWidth) : CW'(DataWidth);
    assign wrap      = tick && cnt == len - CW'(1);
    assign cmd_done  = state == CMD && wrap;
    assign addr_done = state == ADDR && wrap;
    assign word_done = state == WDATA && wrap;
    assign load      = state == RDATA && tick && cnt == '0;
    assign stat_load = state == STATUS && tick && cnt == '0;
    assign free      = ~req_q & ~rd_out;
    assign rv_ok     = rvalid_i & rd_out & ~drop & ~cs_s;
    assign avail     = rbuf_v | rv_ok;
    assign word      = rbuf_v ? rbuf : rv_ok ? rdata_i : DataWidth'(32'hDEADBEEF);
    assign rd_trig   = (addr_done & is_read) | load;
    assign rd_issue  = (rd_trig | rd_pend) & free & ~cs_s;
    assign wr_go     = word_done & free;
    assign inflight  = (rd_out & ~rvalid_i) | (req_q & ~we_q);

`ifdef SPI_TGT_STATUS_CMD_EN
    logic late, ovf;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            late <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            late <= cs_s && state == STATUS ? 1'b0 : load && !avail ? 1'b1 : late;
            ovf  <= cs_s && state == STATUS ? 1'b0 : word_done && !free ? 1'b1 : ovf;
        end
    end
    assign status_cmd = sin_nxt[7:0] == 8'h05;
    assign stat_byte  = {6'b0, late, ovf};
`else
    assign status_cmd = 1'b0;
    assign stat_byte  = 8'h00;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) state_nxt = IDLE;
        else case (state)
            IDLE:    state_nxt = cs_fall ? CMD : IDLE;
            CMD:     state_nxt = !cmd_done ? CMD : sin_nxt[7:0] == 8'h02 || sin_nxt[7:0] == 8'h03 ? ADDR : status_cmd ? STATUS : IGNORE;
            ADDR:    state_nxt = !addr_done ? ADDR : is_read ? DUMMY : WDATA;
            DUMMY:   state_nxt = wrap ? RDATA : DUMMY;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        spi_miso_en_o = state == DUMMY || state == RDATA || state == STATUS;
        spi_miso_o    = sout[DataWidth-1];
        req_o         = req_q;
        we_o          = we_q;
        addr_o        = addr_q;
        wdata_o       = wdata_q;
        be_o          = {(DataWidth/8){req_q}};
        busy_o        = ~cs_s | req_q | rd_out;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sr  <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            sck_d   <= 1'b0;
            cs_d    <= 1'b1;
            cnt     <= '0;
            sin     <= '0;
            sout    <= '0;
            is_read <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cur     <= '0;
            rd_out  <= 1'b0;
            rd_pend <= 1'b0;
            rbuf    <= '0;
            rbuf_v  <= 1'b0;
            drop    <= 1'b0;
        end else begin
            sck_sr  <= SyncStages'({sck_sr, spi_sck_i});
            cs_sr   <= SyncStages'({cs_sr, spi_cs_ni});
            mosi_sr <= SyncStages'({mosi_sr, spi_mosi_i});
            sck_d   <= sck_s;
            cs_d    <= cs_s;
            cnt     <= cs_s || state_nxt != state ? '0 : tick ? (wrap ? '0 : cnt + 1'b1) : cnt;
            if (rise) sin <= sin_nxt;
            if (cmd_done) is_read <= sin_nxt[0];
            if (load) sout <= word;
            else if (stat_load) sout <= {stat_byte, {(DataWidth-8){1'b0}}};
            else if (tick && (state == RDATA || state == STATUS)) sout <= sout << 1;
            if (req_q && gnt_i) req_q <= 1'b0;
            else if (rd_issue || wr_go) begin
                req_q  <= 1'b1;
                we_q   <= wr_go;
                addr_q <= rd_issue && addr_done ? cap_addr : cur;
            end
            if (wr_go) wdata_q <= sin_nxt[DataWidth-1:0];
            rd_out  <= req_q && gnt_i && !we_q ? 1'b1 : rvalid_i ? 1'b0 : rd_out;
            rd_pend <= cs_s || rd_issue ? 1'b0 : rd_trig ? 1'b1 : rd_pend;
            cur     <= addr_done ? cap_addr + (rd_issue ? STEP : '0) : rd_issue || (req_q && gnt_i && we_q) ? cur + STEP : cur;
            rbuf_v  <= cs_s || load ? 1'b0 : rv_ok ? 1'b1 : rbuf_v;
            if (rv_ok) rbuf <= rdata_i;
            // data of a read that was abandoned (cs rise or late substitution) must not reach a later word
            drop    <= ((cs_s | (load & ~avail)) & inflight) | (drop & ~(rvalid_i & rd_out));
        end
    end
endmodule

// File: tb/tb_spi_target_bridge.sv
// tb_spi_target_bridge: drives SPI host transactions and scoreboards memory requests and MISO words.
module tb_spi_target_bridge;
    logic clk = 1'b0, rst = 1'b1;
    logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, miso_en, req, we, gnt = 1'b0, rvalid = 1'b0, busy;
    logic [31:0] addr, wdata, rdata = '0;
    logic [3:0] be;
    int n_cmp = 0, n_bad = 0;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} req_t;
    req_t exp_q[$];
    req_t e;
    bit gnt_ok = 1'b1, en_seen = 1'b0;
    int gnt_lat = 0, rv_lat = 1, wcnt = 0, rv_cnt = 0;
    logic [31:0] rv_data;
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    spi_target_bridge dut (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_en_o(miso_en), .req_o(req), .we_o(we), .addr_o(addr),
        .wdata_o(wdata), .be_o(be), .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .busy_o(busy)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a ^ 32'hA5A5_A5A5;
    endfunction

    // memory responder: grants after gnt_lat cycles, returns read data rv_lat cycles after the grant
    always @(negedge clk) begin
        gnt = 1'b0;
        rvalid = 1'b0;
        if (miso_en) en_seen = 1'b1;
        if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
                rvalid = 1'b1;
                rdata = rv_data;
            end
        end
        if (req && !rst) begin
            if (gnt_ok && wcnt >= gnt_lat) begin
                gnt = 1'b1;
                wcnt = 0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL req_unexpected: got we=%0b addr=%h wdata=%h, want no request", we, addr, wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({we, addr, we ? wdata : 32'h0, be} !== {e.we, e.addr, e.we ? e.wdata : 32'h0, 4'hF}) begin
                        n_bad++;
                        $display("FAIL req_match: got we=%0b addr=%h wdata=%h be=%h, want we=%0b addr=%h wdata=%h be=f",
                                 we, addr, wdata, be, e.we, e.addr, e.wdata);
                    end
                end
                if (!we) begin
                    rv_cnt = rv_lat;
                    rv_data = mem_rd(addr);
                end
            end else wcnt++;
        end else wcnt = 0;
    end

    task automatic bits(input logic [63:0] v, input int n, output logic [63:0] r);
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sck = 1'b0;
            mosi = v[i];
            repeat (6) @(negedge clk);
            r = {r[62:0], miso};
            sck = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic cs_assert;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // chip select is released while sck is still high so no trailing fall reaches the target
    task automatic cs_release;
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        sck = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_drain: pending=%0d busy=%b, want pending=0 busy=0", name, exp_q.size(), busy);
        end
        exp_q.delete();
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        logic [63:0] r;
        cs_assert();
        bits(64'h02, 8, r);
        bits({32'h0, a}, 32, r);
        bits({32'h0, d}, 32, r);
        cs_release();
    endtask

`ifdef SPI_TGT_STATUS_CMD_EN
    task automatic test_status(input logic [7:0] want, input string name);
        logic [63:0] r;
        cs_assert();
        bits(64'h05, 8, r);
        bits(64'h0, 8, r);
        cs_release();
        n_cmp++;
        if (r[7:0] !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, r[7:0], want);
        end
    endtask
`endif

    task automatic test_reset;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({miso, miso_en, req, we, addr, wdata, be, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%h busy=%b miso_en=%b, want all 0",
                     req, we, addr, wdata, be, busy, miso_en);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write;
        gnt_lat = 3;
        exp_q.push_back('{1'b1, 32'h0000_1000, 32'hCAFE_BABE});
        write_word(32'h0000_1000, 32'hCAFE_BABE);
        drain("write");
        gnt_lat = 0;
    endtask

    task automatic test_read_burst;
        logic [63:0] r;
        mem[32'h2000] = 32'h1122_3344;
        mem[32'h2004] = 32'h5566_7788;
        exp_q.push_back('{1'b0, 32'h2000, 32'h0});
        exp_q.push_back('{1'b0, 32'h2004, 32'h0});
        exp_q.push_back('{1'b0, 32'h2008, 32'h0});
        cs_assert();
        bits(64'h03, 8, r);
        bits(64'h2000, 32, r);
        bits(64'h0, 8, r);
        n_cmp++;
        if (miso_en !== 1'b1) begin
            n_bad++;
            $display("FAIL read_miso_en: got %b, want 1", miso_en);
        end
        bits(64'h0, 64, r);
        cs_release();
        n_cmp++;
        if (r !== 64'h1122_3344_5566_7788) begin
            n_bad++;
            $display("FAIL read_burst_data: got %h, want 1122334455667788", r);
        end
        drain("read_burst");
    endtask

    task automatic test_late;
        logic [63:0] r;
        rv_lat = 150;
        exp_q.push_back('{1'b0, 32'h3000, 32'h0});
        exp_q.push_back('{1'b0, 32'h3004, 32'h0});
        cs_assert();
        bits(64'h03, 8, r);
        bits(64'h3000, 32, r);
        bits(64'h0, 8, r);
        bits(64'h0, 32, r);
        cs_release();
        n_cmp++;
        if (r[31:0] !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL late_data: got %h, want deadbeef", r[31:0]);
        end
        drain("late");
        rv_lat = 1;
`ifdef SPI_TGT_STATUS_CMD_EN
        test_status(8'h02, "late_status");
        test_status(8'h00, "late_status_cleared");
`endif
    endtask

    task automatic test_overflow;
        logic [63:0] r;
        gnt_ok = 1'b0;
        exp_q.push_back('{1'b1, 32'h5000, 32'h1111_1111});
        cs_assert();
        bits(64'h02, 8, r);
        bits(64'h5000, 32, r);
        bits(64'h1111_1111, 32, r);
        bits(64'h2222_2222, 32, r);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (req !== 1'b1 || wdata !== 32'h1111_1111 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_hold: got req=%b wdata=%h busy=%b, want req=1 wdata=11111111 busy=1", req, wdata, busy);
        end
        cs_release();
        gnt_ok = 1'b1;
        drain("overflow");
`ifdef SPI_TGT_STATUS_CMD_EN
        test_status(8'h01, "ovf_status");
        test_status(8'h00, "ovf_status_cleared");
`endif
    endtask

    task automatic test_abort;
        logic [63:0] r;
        cs_assert();
        bits(64'h02, 8, r);
        bits(64'h6000, 32, r);
        bits(64'hABCDE, 20, r);
        cs_release();
        drain("abort");
        n_cmp++;
        if (miso_en !== 1'b0 || req !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got miso_en=%b req=%b, want 0 0", miso_en, req);
        end
        exp_q.push_back('{1'b1, 32'h6000, 32'h0BAD_F00D});
        write_word(32'h6000, 32'h0BAD_F00D);
        drain("after_abort");
    endtask

    task automatic test_ignore(input logic [7:0] cmd, input string name);
        logic [63:0] r;
        cs_assert();
        en_seen = 1'b0;
        bits({56'h0, cmd}, 8, r);
        bits(64'h12_3456_789A, 40, r);
        cs_release();
        n_cmp++;
        if (en_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_miso_en: got en_seen=%b, want 0", name, en_seen);
        end
        drain(name);
    endtask

    task automatic test_reset_mid;
        logic [63:0] r;
        gnt_ok = 1'b0;
        cs_assert();
        bits(64'h03, 8, r);
        bits(64'h7000, 32, r);
        bits(64'h0, 4, r);
        n_cmp++;
        if (req !== 1'b1 || miso_en !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_read_state: got req=%b miso_en=%b, want 1 1", req, miso_en);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({miso, miso_en, req, we, addr, wdata, be, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got req=%b addr=%h miso_en=%b busy=%b, want all 0", req, addr, miso_en, busy);
        end
        cs_n = 1'b1;
        sck = 1'b0;
        rv_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        gnt_ok = 1'b1;
        repeat (6) @(negedge clk);
        exp_q.push_back('{1'b0, 32'h7000, 32'h0});
        exp_q.push_back('{1'b0, 32'h7004, 32'h0});
        cs_assert();
        bits(64'h03, 8, r);
        bits(64'h7000, 32, r);
        bits(64'h0, 8, r);
        bits(64'h0, 32, r);
        cs_release();
        n_cmp++;
        if (r[31:0] !== mem_rd(32'h7000)) begin
            n_bad++;
            $display("FAIL after_reset_read: got %h, want %h", r[31:0], mem_rd(32'h7000));
        end
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_burst();
        test_late();
        test_overflow();
        test_abort();
        test_ignore(8'hA5, "ignore_a5");
`ifndef SPI_TGT_STATUS_CMD_EN
        test_ignore(8'h05, "ignore_05");
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at time limit, want completion");
        $fatal(1);
    end
endmodule
